// File: rtl/mips_pkg.sv
// mips_pkg: shared instruction field positions and fetch constants.
package mips_pkg;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;
    typedef enum logic [1:0] {ADV_NORMAL, ADV_STALL, ADV_REDIRECT} adv_e;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detection against the ID instruction.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_valid_i,
    output logic       stall_o
);
    // Rs and Rt compared for every opcode: conservative but never misses a hazard.
    assign stall_o = ex_mem_read_i && (ex_rt_i != 5'd0) && id_valid_i &&
                     ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC, fetch and IF/ID register with redirect and load-use stall.
// Define HAZARD_STALL_EN to enable load-use stalling; otherwise Stall is tied to 0.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [31:0]            IF_PC,
    input  logic [31:0]            IF_Instr,
    input  logic                   EX_Redirect,
    input  logic [31:0]            EX_Target,
    input  logic                   EX_MemRead,
    input  logic [4:0]             EX_Rt,
    output logic [31:0]            ID_Instr,
    output logic [31:0]            ID_PCinc,
    output logic [3:0]             ID_PC_MSBs,
    output logic [4:0]             ID_Rs,
    output logic [4:0]             ID_Rt,
    output logic [4:0]             ID_Rd,
    output logic                   ID_Valid,
    output logic                   IDEX_Bubble,
    output logic                   Stall,
    output logic [STALL_CNT_W-1:0] Stall_Count
);
`ifdef HAZARD_STALL_EN
    localparam bit HAZ_EN = 1'b1;
`else
    localparam bit HAZ_EN = 1'b0;
`endif
    logic [31:0]            pc_q, pc_d, instr_q, instr_d, pcinc_q, pcinc_d, pc_next;
    logic                   valid_q, valid_d, hz_stall;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    adv_e                   adv;

    hazard_detect u_hazard (
        .ex_mem_read_i (EX_MemRead),
        .ex_rt_i       (EX_Rt),
        .id_rs_i       (ID_Rs),
        .id_rt_i       (ID_Rt),
        .id_valid_i    (valid_q),
        .stall_o       (hz_stall)
    );

    assign Stall       = HAZ_EN & hz_stall;
    assign IDEX_Bubble = Stall | EX_Redirect;
    assign pc_next     = pc_q + PC_INC;

    // Redirect wins over stall: the stalled ID instruction is on the squashed path.
    always_comb begin
        adv     = EX_Redirect ? ADV_REDIRECT : Stall ? ADV_STALL : ADV_NORMAL;
        pc_d    = (adv == ADV_REDIRECT) ? EX_Target : (adv == ADV_STALL) ? pc_q : pc_next;
        instr_d = (adv == ADV_REDIRECT) ? NOP : (adv == ADV_STALL) ? instr_q : IF_Instr;
        pcinc_d = (adv == ADV_NORMAL) ? pc_next : pcinc_q;
        valid_d = (adv == ADV_REDIRECT) ? 1'b0 : (adv == ADV_STALL) ? valid_q : 1'b1;
        cnt_d   = (adv == ADV_STALL && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            pcinc_q <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcinc_q <= pcinc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IF_PC       = pc_q;
    assign ID_Instr    = instr_q;
    assign ID_PCinc    = pcinc_q;
    assign ID_PC_MSBs  = pcinc_q[31:28];
    assign ID_Rs       = instr_q[RS_MSB:RS_LSB];
    assign ID_Rt       = instr_q[RT_MSB:RT_LSB];
    assign ID_Rd       = instr_q[RD_MSB:RD_LSB];
    assign ID_Valid    = valid_q;
    assign Stall_Count = cnt_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed self-checking bench for if_id_stage (both HAZARD_STALL_EN builds).
module tb_if_id_stage;
`ifdef HAZARD_STALL_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b0;
    logic [31:0] IF_PC, IF_Instr, EX_Target = 32'h0, ID_Instr, ID_PCinc;
    logic        EX_Redirect = 1'b0, EX_MemRead = 1'b0;
    logic [4:0]  EX_Rt = 5'd0, ID_Rs, ID_Rt, ID_Rd;
    logic [3:0]  ID_PC_MSBs;
    logic        ID_Valid, IDEX_Bubble, Stall;
    logic [1:0]  Stall_Count;
    int          errors = 0, checks = 0;

    if_id_stage #(.RESET_PC(32'h100), .STALL_CNT_W(2)) dut (
        .clk(clk), .reset(reset), .IF_PC(IF_PC), .IF_Instr(IF_Instr),
        .EX_Redirect(EX_Redirect), .EX_Target(EX_Target), .EX_MemRead(EX_MemRead),
        .EX_Rt(EX_Rt), .ID_Instr(ID_Instr), .ID_PCinc(ID_PCinc), .ID_PC_MSBs(ID_PC_MSBs),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Valid(ID_Valid),
        .IDEX_Bubble(IDEX_Bubble), .Stall(Stall), .Stall_Count(Stall_Count)
    );

    always #5 clk = ~clk;

    // Instruction memory: two fixed words, everything else is lui with the address low half.
    always_comb
        IF_Instr = (IF_PC == 32'h100) ? 32'h2009_0005 :
                   (IF_PC == 32'h104) ? 32'h0109_5020 : {16'h3C00, IF_PC[15:0]};

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; EX_Redirect = 1'b0; EX_MemRead = 1'b0; EX_Rt = 5'd0; EX_Target = 32'h0;
        tick(); tick();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (IF_PC !== 32'h100) begin errors++; $display("FAIL rst_pc got %h exp %h", IF_PC, 32'h100); end
        checks++; if (ID_Instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", ID_Instr); end
        checks++; if (ID_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ID_Valid); end
        checks++; if (Stall_Count !== 2'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", Stall_Count); end
        checks++; if ({Stall, IDEX_Bubble} !== 2'b00) begin errors++; $display("FAIL rst_bubble got %b exp 00", {Stall, IDEX_Bubble}); end
    endtask

    task automatic test_seq_fetch();
        tick();
        checks++; if (ID_Instr !== 32'h2009_0005) begin errors++; $display("FAIL seq_instr got %h exp 20090005", ID_Instr); end
        checks++; if ({ID_Rs, ID_Rt} !== {5'd0, 5'd9}) begin errors++; $display("FAIL seq_rsrt got %0d/%0d exp 0/9", ID_Rs, ID_Rt); end
        checks++; if (ID_PCinc !== 32'h104) begin errors++; $display("FAIL seq_pcinc got %h exp 104", ID_PCinc); end
        checks++; if (ID_Valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %b exp 1", ID_Valid); end
        tick();
        checks++; if (IF_PC !== 32'h108) begin errors++; $display("FAIL seq_pc got %h exp 108", IF_PC); end
        checks++; if ({ID_Rs, ID_Rt, ID_Rd} !== {5'd8, 5'd9, 5'd10}) begin errors++; $display("FAIL seq_fields got %0d/%0d/%0d exp 8/9/10", ID_Rs, ID_Rt, ID_Rd); end
        checks++; if (ID_PCinc !== 32'h108) begin errors++; $display("FAIL seq_pcinc2 got %h exp 108", ID_PCinc); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        EX_MemRead = 1'b1; EX_Rt = 5'd9;
        #1;
        checks++; if (Stall !== HAZ) begin errors++; $display("FAIL lu_stall got %b exp %b", Stall, HAZ); end
        checks++; if (IDEX_Bubble !== HAZ) begin errors++; $display("FAIL lu_bubble got %b exp %b", IDEX_Bubble, HAZ); end
        tick();
        checks++; if (IF_PC !== (HAZ ? 32'h108 : 32'h10C)) begin errors++; $display("FAIL lu_pc got %h exp %h", IF_PC, HAZ ? 32'h108 : 32'h10C); end
        checks++; if (ID_Instr !== (HAZ ? 32'h0109_5020 : 32'h3C00_0108)) begin errors++; $display("FAIL lu_instr got %h", ID_Instr); end
        checks++; if (Stall_Count !== (HAZ ? 2'd1 : 2'd0)) begin errors++; $display("FAIL lu_cnt got %0d exp %0d", Stall_Count, HAZ ? 1 : 0); end
        @(negedge clk);
        EX_Rt = 5'd0;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL lu_rt0 got %b exp 0", Stall); end
        EX_MemRead = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        tick();
        @(negedge clk);
        EX_Redirect = 1'b1; EX_Target = 32'h200; EX_MemRead = 1'b1; EX_Rt = 5'd9;
        #1;
        checks++; if (IDEX_Bubble !== 1'b1) begin errors++; $display("FAIL rd_bubble got %b exp 1", IDEX_Bubble); end
        tick();
        EX_Redirect = 1'b0; EX_MemRead = 1'b0; EX_Rt = 5'd0;
        checks++; if (IF_PC !== 32'h200) begin errors++; $display("FAIL rd_pc got %h exp 200", IF_PC); end
        checks++; if ({ID_Instr, ID_Valid} !== 33'h0) begin errors++; $display("FAIL rd_squash got %h/%b exp 0/0", ID_Instr, ID_Valid); end
        checks++; if (Stall_Count !== 2'd0) begin errors++; $display("FAIL rd_cnt got %0d exp 0", Stall_Count); end
        tick();
        checks++; if (IF_PC !== 32'h204) begin errors++; $display("FAIL rd_pc2 got %h exp 204", IF_PC); end
        checks++; if ({ID_Instr, ID_Valid} !== {32'h3C00_0200, 1'b1}) begin errors++; $display("FAIL rd_target_instr got %h/%b", ID_Instr, ID_Valid); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        EX_Redirect = 1'b1; EX_Target = 32'hFFFF_FFFC;
        tick();
        EX_Redirect = 1'b0;
        checks++; if (IF_PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pc got %h exp fffffffc", IF_PC); end
        tick();
        checks++; if (IF_PC !== 32'h0) begin errors++; $display("FAIL wr_wrap got %h exp 0", IF_PC); end
        checks++; if ({ID_PCinc, ID_PC_MSBs} !== 36'h0) begin errors++; $display("FAIL wr_pcinc got %h/%h exp 0/0", ID_PCinc, ID_PC_MSBs); end
        checks++; if (ID_Instr !== 32'h3C00_FFFC) begin errors++; $display("FAIL wr_instr got %h exp 3c00fffc", ID_Instr); end
        @(negedge clk);
        EX_Redirect = 1'b1; EX_Target = 32'h8000_0203;
        tick();
        EX_Redirect = 1'b0;
        tick();
        checks++; if (IF_PC !== 32'h8000_0207) begin errors++; $display("FAIL wr_unaligned got %h exp 80000207", IF_PC); end
        checks++; if (ID_PC_MSBs !== 4'h8) begin errors++; $display("FAIL wr_msbs got %h exp 8", ID_PC_MSBs); end
    endtask

    task automatic test_saturation();
        do_reset();
        tick();
        @(negedge clk);
        EX_MemRead = 1'b1; EX_Rt = 5'd9;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (Stall_Count !== (HAZ ? 2'd3 : 2'd0)) begin errors++; $display("FAIL sat_cnt got %0d exp %0d", Stall_Count, HAZ ? 3 : 0); end
        checks++; if (IF_PC !== (HAZ ? 32'h104 : 32'h118)) begin errors++; $display("FAIL sat_pc got %h exp %h", IF_PC, HAZ ? 32'h104 : 32'h118); end
        @(negedge clk);
        EX_MemRead = 1'b0; EX_Rt = 5'd0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reset = 1'b0; EX_Redirect = 1'b1; EX_Target = 32'h300;
        tick();
        checks++; if ({IF_PC, ID_Valid} !== {32'h100, 1'b0}) begin errors++; $display("FAIL rm_pc got %h/%b exp 100/0", IF_PC, ID_Valid); end
        @(negedge clk);
        reset = 1'b1; EX_Redirect = 1'b0;
        tick();
        checks++; if (ID_PCinc !== 32'h104) begin errors++; $display("FAIL rm_pcinc got %h exp 104", ID_PCinc); end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_load_use();
        test_redirect();
        test_wrap();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
